// File: rtl/ccl_window_gen_pkg.sv
// Shared types and constants for the CCL window generator slice.
// Label word width and a small helper for counter/address sizing.
package ccl_window_gen_pkg;

    localparam int WORD_SIZE = 16;

    typedef logic [WORD_SIZE-1:0] label_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int bits_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ccl_window_gen_ram_dr_sw.sv
// Dual-read, single-write RAM with registered reads; holds one row of labels.
// Contents are never cleared; the caller masks stale data.
module ram_dr_sw #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr1,
    input  logic [ADDR_WIDTH-1:0] r_addr2,
    output logic [DATA_WIDTH-1:0] r_data1,
    output logic [DATA_WIDTH-1:0] r_data2
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr] <= w_data;
        end
        r_data1 <= mem[r_addr1];
        r_data2 <= mem[r_addr2];
    end

endmodule

// File: rtl/ccl_window_gen.sv
// Raster-order feeder for the CCL labeller: issues each pixel with its causal
// neighbourhood A/B/C/D and writes the returned label back into a one-row buffer.
module ccl_window_gen
    import ccl_window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int LAT        = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_pixel,
    output logic                 en,
    output logic [WORD_SIZE-1:0] A,
    output logic [WORD_SIZE-1:0] B,
    output logic [WORD_SIZE-1:0] C,
    output logic [WORD_SIZE-1:0] D,
    output logic [WORD_SIZE-1:0] p,
    output logic [31:0]          x,
    output logic [31:0]          y,
    input  logic [WORD_SIZE-1:0] q,
    output logic                 frame_done
);

    localparam int COL_W = bits_for(IMG_WIDTH);
    localparam int ROW_W = bits_for(IMG_HEIGHT);
    localparam int CNT_W = bits_for(LAT + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] x_q, x_d;
    logic [ROW_W-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    label_t           pix_q, pix_d;
    label_t           a_reg_q, a_reg_d;
    label_t           d_reg_q, d_reg_d;
    label_t           b_hold_q, b_hold_d;
    logic             first_row_q, first_row_d;
    logic             frame_done_q, frame_done_d;
    logic             en_q;

    label_t           lb_b, lb_c;
    label_t           b_masked;
    logic             lb_we;
    logic [COL_W-1:0] lb_raddr2;

    assign lb_raddr2 = col_q + 1'b1;

    ram_dr_sw #(
        .ADDR_WIDTH (COL_W),
        .DATA_WIDTH (WORD_SIZE)
    ) u_line_buf (
        .clk     (clk),
        .we      (lb_we),
        .w_addr  (col_q),
        .w_data  (q),
        .r_addr1 (col_q),
        .r_addr2 (lb_raddr2),
        .r_data1 (lb_b),
        .r_data2 (lb_c)
    );

    assign b_masked = first_row_q ? '0 : lb_b;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        x_d          = x_q;
        y_d          = y_q;
        cnt_d        = cnt_q;
        pix_d        = pix_q;
        a_reg_d      = a_reg_q;
        d_reg_d      = d_reg_q;
        b_hold_d     = b_hold_q;
        first_row_d  = first_row_q;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        in_ready     = 1'b0;
        p            = '0;
        A            = '0;
        B            = '0;
        C            = '0;
        D            = '0;
        x            = 32'(x_q);
        y            = 32'(y_q);

        unique case (state_q)
            S_IDLE: begin
                // The RAM read of col/col+1 runs every cycle, so the accept cycle primes ISSUE.
                in_ready = en_q;
                if (en_q && in_valid) begin
                    pix_d   = in_pixel;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                p        = pix_q;
                x        = 32'(col_q);
                y        = 32'(row_q);
                B        = b_masked;
                C        = (first_row_q || col_q == COL_LAST) ? '0 : lb_c;
                A        = (first_row_q || col_q == '0) ? '0 : a_reg_q;
                D        = (col_q == '0) ? '0 : d_reg_q;
                x_d      = col_q;
                y_d      = row_q;
                b_hold_d = b_masked;
                cnt_d    = '0;
                state_d  = (LAT == 1) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                if (int'(cnt_q) >= LAT - 2) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                lb_we   = 1'b1;
                d_reg_d = q;
                a_reg_d = b_hold_q;
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    a_reg_d = '0;
                    d_reg_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d        = '0;
                        first_row_d  = 1'b1;
                        frame_done_d = 1'b1;
                    end else begin
                        row_d       = row_q + 1'b1;
                        first_row_d = 1'b0;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            pix_q        <= '0;
            a_reg_q      <= '0;
            d_reg_q      <= '0;
            b_hold_q     <= '0;
            first_row_q  <= 1'b1;
            frame_done_q <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            pix_q        <= pix_d;
            a_reg_q      <= a_reg_d;
            d_reg_q      <= d_reg_d;
            b_hold_q     <= b_hold_d;
            first_row_q  <= first_row_d;
            frame_done_q <= frame_done_d;
            en_q         <= 1'b1;
        end
    end

    assign en         = en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ccl_window_gen.sv
// Directed bench for ccl_window_gen on a 4x2 image with LAT=2; expected
// neighbourhoods come from an image-domain label model queued at issue time.
module tb_ccl_window_gen;
    import ccl_window_gen_pkg::*;

    localparam int W = 4;
    localparam int H = 2;
    localparam int L = 2;
    localparam logic [WORD_SIZE-1:0] Q_JUNK = 16'hBEEF;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] in_pixel = '0;
    logic                 en;
    logic [WORD_SIZE-1:0] A, B, C, D, p;
    logic [31:0]          x, y;
    logic [WORD_SIZE-1:0] q = Q_JUNK;
    logic                 frame_done;

    typedef struct {
        logic [WORD_SIZE-1:0] p, a, b, c, d;
        logic [31:0]          x, y;
    } exp_t;

    exp_t                 exp_q[$];
    logic [WORD_SIZE-1:0] lab [H][W];
    int                   mcol = 0;
    int                   mrow = 0;
    int                   checks = 0;
    int                   fails = 0;

    ccl_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .LAT        (L)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .en         (en),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .p          (p),
        .x          (x),
        .y          (y),
        .q          (q),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_bubble(input string tag, input logic [31:0] ex, input logic [31:0] ey);
        check({tag, "_p"}, 32'(p), 32'(0));
        check({tag, "_abcd"}, {A | B, C | D}, 32'(0));
        check({tag, "_x"}, x, ex);
        check({tag, "_y"}, y, ey);
    endtask

    // Expected neighbourhood straight from the image: labels above and to the left.
    task automatic push_expect(input logic [WORD_SIZE-1:0] pix);
        exp_t e;
        e.p = pix;
        e.x = 32'(mcol);
        e.y = 32'(mrow);
        e.a = (mrow > 0 && mcol > 0)     ? lab[mrow-1][mcol-1] : '0;
        e.b = (mrow > 0)                 ? lab[mrow-1][mcol]   : '0;
        e.c = (mrow > 0 && mcol < W - 1) ? lab[mrow-1][mcol+1] : '0;
        e.d = (mcol > 0)                 ? lab[mrow][mcol-1]   : '0;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after capture (or after an abort).
    task automatic send_pixel(input logic [WORD_SIZE-1:0] pix, input logic [WORD_SIZE-1:0] qv,
                              input bit abort_in_wait);
        exp_t e;
        int   n;
        bit   last;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'(1));
        if (in_ready !== 1'b1) return;

        push_expect(pix);
        in_pixel = pix;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_pixel = 16'h5A5A;

        check("issue_qdepth", 32'(exp_q.size()), 32'(1));
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        $display("issue (%0d,%0d) p=%0h A=%0h B=%0h C=%0h D=%0h exp A=%0h B=%0h C=%0h D=%0h",
                 x, y, p, A, B, C, D, e.a, e.b, e.c, e.d);
        check("issue_p", 32'(p), 32'(e.p));
        check("issue_A", 32'(A), 32'(e.a));
        check("issue_B", 32'(B), 32'(e.b));
        check("issue_C", 32'(C), 32'(e.c));
        check("issue_D", 32'(D), 32'(e.d));
        check("issue_x", x, e.x);
        check("issue_y", y, e.y);
        check("issue_busy", {31'd0, in_ready}, 32'(0));
        check("issue_en", {31'd0, en}, 32'(1));
        check("issue_fd", {31'd0, frame_done}, 32'(0));

        for (int i = 0; i < L - 1; i++) begin
            @(negedge clk);
            if (abort_in_wait && i == 0) begin
                reset_n = 1'b0;
                @(negedge clk);
                check("rst_in_ready", {31'd0, in_ready}, 32'(0));
                check("rst_en", {31'd0, en}, 32'(0));
                check_bubble("rst", 32'(0), 32'(0));
                reset_n = 1'b1;
                @(negedge clk);
                check("rst_rel_ready", {31'd0, in_ready}, 32'(1));
                mcol = 0;
                mrow = 0;
                $display("reset during wait at (%0d,%0d)", e.x, e.y);
                return;
            end
            check_bubble("wait", e.x, e.y);
        end

        @(negedge clk);
        check_bubble("capture", e.x, e.y);
        q = qv;
        @(negedge clk);
        q = Q_JUNK;
        last = (mcol == W - 1 && mrow == H - 1);
        check("idle_ready", {31'd0, in_ready}, 32'(1));
        check("frame_done", {31'd0, frame_done}, {31'd0, last});
        lab[mrow][mcol] = qv;
        if (mcol == W - 1) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    initial begin
        logic [WORD_SIZE-1:0] f2_pix [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
        logic [WORD_SIZE-1:0] f2_q   [8] = '{1, 1, 0, 2, 3, 3, 3, 2};
        logic [WORD_SIZE-1:0] f3_pix [4] = '{1, 1, 1, 1};
        logic [WORD_SIZE-1:0] f3_q   [4] = '{4, 4, 4, 4};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'(0));
        check("rst_en", {31'd0, en}, 32'(0));
        check("rst_fd", {31'd0, frame_done}, 32'(0));
        check_bubble("rst", 32'(0), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_en", {31'd0, en}, 32'(1));

        // Frame 1: all background
        for (int i = 0; i < W * H; i++) send_pixel('0, '0, 1'b0);
        @(negedge clk);
        check("fd_pulse_end", {31'd0, frame_done}, 32'(0));

        // Frame 2: labels reach the neighbourhood; right edge masks C, left edge masks A/D
        for (int i = 0; i < W * H; i++) send_pixel(f2_pix[i], f2_q[i], 1'b0);

        // Frame 3: first row ignores the non-zero line buffer
        for (int i = 0; i < W; i++) send_pixel(f3_pix[i], f3_q[i], 1'b0);

        // Reset during WAIT, then restart at (0,0)
        send_pixel(16'd1, 16'd9, 1'b1);
        send_pixel(16'd1, 16'd7, 1'b0);
        send_pixel(16'd1, 16'd7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
